// File: rtl/spi_sd_multi_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_sd_multi_rd_ctrl
// Purpose  : Wishbone master sequencer for the SPI/SD host register file.
//            Brings the card up (with retries), then serves multi-sector read
//            requests. Each 512-byte sector is streamed into a downstream
//            sector buffer, and the controller waits for buf_ready between
//            sectors.
// Ports    : wb_clk_i/wb_rst_i  - clock, asynchronous active-high reset
//            wb_*               - 8-bit Wishbone master (adr/dat/we/stb/ack)
//            rd_start/sector/count - read request (one-cycle start pulse)
//            buf_ready          - consumer can accept the next sector
//            init_done/init_err - card state (init_err sticky until reset)
//            rd_busy/rd_done/rd_err - request status and completion pulses
//            buf_wr/addr/data/sect  - sector buffer write port
//            state              - FSM state for debug
// Revision : 1.0 - initial release
// ============================================================================
module spi_sd_multi_rd_ctrl #(
    parameter int SEC_ADDR_W = 23,
    parameter int SECT_CNT_W = 8,
    parameter bit BLOCK_ADDR = 1'b0,
    parameter int INIT_DELAY = 15,
    parameter int POLL_LIMIT = 4095,
    parameter int INIT_RETRY = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    output logic [7:0]            wb_adr_o,
    output logic [7:0]            wb_dat_o,
    input  logic [7:0]            wb_dat_i,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    input  logic                  rd_start,
    input  logic [SEC_ADDR_W-1:0] rd_sector,
    input  logic [SECT_CNT_W-1:0] rd_count,
    input  logic                  buf_ready,
    output logic                  init_done,
    output logic                  init_err,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  rd_err,
    output logic                  buf_wr,
    output logic [8:0]            buf_addr,
    output logic [7:0]            buf_data,
    output logic [SECT_CNT_W-1:0] buf_sect,
    output logic [3:0]            state
);

    // Register map of the host core
    localparam logic [7:0] c_REG_TYPE   = 8'h02;
    localparam logic [7:0] c_REG_START  = 8'h03;
    localparam logic [7:0] c_REG_STATUS = 8'h04;
    localparam logic [7:0] c_REG_ADDR0  = 8'h07;
    localparam logic [7:0] c_REG_FIFO   = 8'h10;
    localparam logic [7:0] c_TYPE_INIT  = 8'h01;
    localparam logic [7:0] c_TYPE_READ  = 8'h02;
    localparam logic [7:0] c_GO         = 8'h01;
    localparam logic [7:0] c_ST_OK      = 8'h00;
    localparam logic [7:0] c_ST_BUSY    = 8'h01;

    // Counter widths carry +2 headroom so a zero parameter never yields a
    // zero-width vector.
    localparam int c_DLY_W  = $clog2(INIT_DELAY + 2);
    localparam int c_POLL_W = $clog2(POLL_LIMIT + 2);
    localparam int c_RTRY_W = $clog2(INIT_RETRY + 2);
    localparam logic [c_DLY_W-1:0]  c_DLY_INIT  = c_DLY_W'(INIT_DELAY);
    localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_LIMIT - 1);
    localparam logic [c_RTRY_W-1:0] c_RTRY_MAX  = c_RTRY_W'(INIT_RETRY);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_INIT_TYPE  = 4'd1,
        ST_INIT_START = 4'd2,
        ST_INIT_POLL  = 4'd3,
        ST_ADDR       = 4'd4,
        ST_RD_TYPE    = 4'd5,
        ST_RD_START   = 4'd6,
        ST_RD_POLL    = 4'd7,
        ST_FIFO_RD    = 4'd8,
        ST_SECT_WAIT  = 4'd9,
        ST_DONE       = 4'd10,
        ST_INIT_FAIL  = 4'd11
    } state_t;

    state_t                  state_q;
    logic [7:0]              adr_q, dat_q, rdat_q;
    logic                    we_q, stb_q;
    logic                    init_done_q, init_err_q;
    logic                    rd_busy_q, rd_done_q, rd_err_q, buf_wr_q;
    logic [8:0]              buf_addr_q;
    logic [SECT_CNT_W-1:0]   buf_sect_q, cnt_q;
    logic [SEC_ADDR_W-1:0]   sector_q;
    logic [1:0]              byte_idx_q;
    logic [c_DLY_W-1:0]      delay_q;
    logic [c_POLL_W-1:0]     poll_q;
    logic [c_RTRY_W-1:0]     retry_q;

    logic                    w_ack;
    logic                    w_bus_req;
    logic [7:0]              w_adr, w_dat, w_addr_byte;
    logic                    w_we;
    logic [31:0]             w_sec32, w_card_addr;

    // Only an ack that lands on an active strobe completes a transfer.
    assign w_ack = stb_q & wb_ack_i;

    assign w_sec32     = 32'(sector_q);
    assign w_card_addr = BLOCK_ADDR ? w_sec32 : (w_sec32 << 9);

    always_comb begin
        w_addr_byte = w_card_addr[7:0];
        case (byte_idx_q)
            2'd0:    w_addr_byte = w_card_addr[7:0];
            2'd1:    w_addr_byte = w_card_addr[15:8];
            2'd2:    w_addr_byte = w_card_addr[23:16];
            default: w_addr_byte = w_card_addr[31:24];
        endcase
    end

    // Bus request belonging to each bus-facing state.
    always_comb begin
        w_bus_req = 1'b1;
        w_adr     = 8'h00;
        w_dat     = 8'h00;
        w_we      = 1'b0;
        case (state_q)
            ST_INIT_TYPE: begin
                w_adr = c_REG_TYPE;  w_dat = c_TYPE_INIT; w_we = 1'b1;
            end
            ST_INIT_START, ST_RD_START: begin
                w_adr = c_REG_START; w_dat = c_GO;        w_we = 1'b1;
            end
            ST_INIT_POLL, ST_RD_POLL: begin
                w_adr = c_REG_STATUS;
            end
            ST_ADDR: begin
                w_adr = c_REG_ADDR0 + {6'd0, byte_idx_q};
                w_dat = w_addr_byte;
                w_we  = 1'b1;
            end
            ST_RD_TYPE: begin
                w_adr = c_REG_TYPE;  w_dat = c_TYPE_READ; w_we = 1'b1;
            end
            ST_FIFO_RD: begin
                w_adr = c_REG_FIFO;
            end
            default: w_bus_req = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            rdat_q      <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            rd_busy_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
            buf_wr_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_sect_q  <= '0;
            cnt_q       <= '0;
            sector_q    <= '0;
            byte_idx_q  <= '0;
            delay_q     <= c_DLY_INIT;
            poll_q      <= '0;
            retry_q     <= '0;
        end else begin
            rd_done_q <= 1'b0;
            rd_err_q  <= 1'b0;
            buf_wr_q  <= 1'b0;

            // buf_addr advances after the write it labelled, so 511 wraps
            // to 0 once the last byte of a sector has been presented.
            if (buf_wr_q) begin
                buf_addr_q <= buf_addr_q + 9'd1;
            end

            // A bus state issues its transfer whenever the strobe is idle;
            // the strobe drops on the cycle after the ack.
            if (w_bus_req && !stb_q) begin
                adr_q <= w_adr;
                dat_q <= w_dat;
                we_q  <= w_we;
                stb_q <= 1'b1;
            end
            if (w_ack) begin
                stb_q  <= 1'b0;
                rdat_q <= wb_dat_i;
            end

            case (state_q)
                ST_IDLE: begin
                    if (delay_q != '0) begin
                        delay_q <= delay_q - c_DLY_W'(1);
                    end else if (!init_done_q && !init_err_q) begin
                        state_q <= ST_INIT_TYPE;
                    end else if (rd_start && init_done_q && !init_err_q) begin
                        sector_q   <= rd_sector;
                        cnt_q      <= rd_count;
                        buf_sect_q <= '0;
                        buf_addr_q <= '0;
                        byte_idx_q <= '0;
                        rd_busy_q  <= 1'b1;
                        state_q    <= (rd_count == '0) ? ST_DONE : ST_ADDR;
                    end
                end
                ST_INIT_TYPE: begin
                    if (w_ack) state_q <= ST_INIT_START;
                end
                ST_INIT_START: begin
                    if (w_ack) begin
                        poll_q  <= '0;
                        state_q <= ST_INIT_POLL;
                    end
                end
                ST_INIT_POLL: begin
                    if (w_ack) begin
                        if (wb_dat_i == c_ST_OK) begin
                            init_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else if (wb_dat_i == c_ST_BUSY && poll_q != c_POLL_LAST) begin
                            poll_q <= poll_q + c_POLL_W'(1);
                        end else if (retry_q < c_RTRY_MAX) begin
                            retry_q <= retry_q + c_RTRY_W'(1);
                            state_q <= ST_INIT_TYPE;
                        end else begin
                            init_err_q <= 1'b1;
                            state_q    <= ST_INIT_FAIL;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_ack) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) state_q <= ST_RD_TYPE;
                    end
                end
                ST_RD_TYPE: begin
                    if (w_ack) state_q <= ST_RD_START;
                end
                ST_RD_START: begin
                    if (w_ack) begin
                        poll_q  <= '0;
                        state_q <= ST_RD_POLL;
                    end
                end
                ST_RD_POLL: begin
                    if (w_ack) begin
                        if (wb_dat_i == c_ST_OK) begin
                            state_q <= ST_FIFO_RD;
                        end else if (wb_dat_i == c_ST_BUSY && poll_q != c_POLL_LAST) begin
                            poll_q <= poll_q + c_POLL_W'(1);
                        end else begin
                            rd_err_q  <= 1'b1;
                            rd_busy_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                ST_FIFO_RD: begin
                    if (w_ack) begin
                        buf_wr_q <= 1'b1;
                        if (buf_addr_q == 9'd511) begin
                            cnt_q <= cnt_q - SECT_CNT_W'(1);
                            if (cnt_q == SECT_CNT_W'(1)) begin
                                state_q <= ST_DONE;
                            end else begin
                                sector_q <= sector_q + SEC_ADDR_W'(1);
                                state_q  <= ST_SECT_WAIT;
                            end
                        end
                    end
                end
                ST_SECT_WAIT: begin
                    // buf_sect moves on only here so it stays stable across
                    // the final write of the previous sector.
                    if (buf_ready) begin
                        buf_sect_q <= buf_sect_q + SECT_CNT_W'(1);
                        state_q    <= ST_ADDR;
                    end
                end
                ST_DONE: begin
                    rd_done_q <= 1'b1;
                    rd_busy_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                ST_INIT_FAIL: begin
                    state_q <= ST_INIT_FAIL;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_stb_o  = stb_q;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;
    assign rd_busy   = rd_busy_q;
    assign rd_done   = rd_done_q;
    assign rd_err    = rd_err_q;
    assign buf_wr    = buf_wr_q;
    assign buf_addr  = buf_addr_q;
    assign buf_data  = rdat_q;
    assign buf_sect  = buf_sect_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: doc/spi_sd_multi_rd_ctrl.md
Name: spi_sd_multi_rd_ctrl

Overview:
- Wishbone master sequencer that drives the SPI/SD host core's register file.
- Runs card init with retry, then services multi-sector read requests, streaming each 512-byte sector into a downstream sector buffer.
- Generalises the single-sector read controller with:
  - sector count per request;
  - byte or block addressing;
  - poll timeout and error reporting;
  - buffer back-pressure between sectors.

Parameters:
SEC_ADDR_W, 23, width of sector address input (max 32)
SECT_CNT_W, 8, width of sector-count input
BLOCK_ADDR, 0, 0 = byte addressing (card address = sector<<9), 1 = block addressing (card address = sector)
INIT_DELAY, 15, cycles after reset before init starts
POLL_LIMIT, 4095, max status polls per transaction before timeout
INIT_RETRY, 2, extra init attempts after a failed init

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset
wb_adr_o  out  8  WB register address
wb_dat_o  out  8  WB write data
wb_dat_i  in  8  WB read data
wb_we_o  out  1  WB write enable
wb_stb_o  out  1  WB strobe
wb_ack_i  in  1  WB acknowledge
rd_start  in  1  one-cycle read request
rd_sector  in  SEC_ADDR_W  first sector
rd_count  in  SECT_CNT_W  sectors to read
buf_ready  in  1  consumer can accept next sector
init_done  out  1  card initialised
init_err  out  1  init failed after all retries (sticky)
rd_busy  out  1  request in progress
rd_done  out  1  one-cycle completion pulse
rd_err  out  1  one-cycle error pulse (timeout or bad status)
buf_wr  out  1  buffer write strobe
buf_addr  out  9  byte index within sector
buf_data  out  8  byte data
buf_sect  out  SECT_CNT_W  sector index within request
state  out  4  FSM state (debug)

Behaviour:
- Reset: wb_rst_i asynchronous, active-high; clock wb_clk_i. All outputs 0 at reset; FSM to IDLE; delay counter loaded with INIT_DELAY; retry count cleared.
- Reset mid-operation aborts immediately; init re-runs after INIT_DELAY.
- WB transaction:
  - cycle 1: load adr/dat/we, stb=1;
  - hold until wb_ack_i; stb=0 on the cycle after ack;
  - read data captured into a register on ack.
- Register map: 0x02 transaction type (1 = init, 2 = read); 0x03 start (write 0x01); 0x04 status; 0x07..0x0A card address bytes 0..3; 0x10 RX FIFO.
- Status decode: 0x01 = busy (poll again); 0x00 = success; any other value = error.
- Poll counter clears per transaction. Reaching POLL_LIMIT without success is an error.
- FSM states: IDLE, INIT_TYPE, INIT_START, INIT_POLL, ADDR, RD_TYPE, RD_START, RD_POLL, FIFO_RD, SECT_WAIT, DONE, INIT_FAIL.
- IDLE:
  - When delay = 0 and !init_done and !init_err: go to INIT_TYPE.
  - Else on rd_start with init_done: latch sector and count, set rd_busy.
  - If the latched count = 0: pulse rd_done next cycle with no bus traffic.
  - rd_start is ignored while busy, before init_done, or when init_err = 1.
- Init sequence: INIT_TYPE -> INIT_START -> INIT_POLL.
  - Success sets init_done.
  - Error or timeout: retry from INIT_TYPE while retries < INIT_RETRY. Otherwise go to INIT_FAIL, set init_err, and stay until reset.
- ADDR:
  - A = BLOCK_ADDR ? sector : sector<<9, zero-extended/truncated to 32 bits.
  - Write bytes A[7:0]..A[31:24] to 0x07..0x0A in order via a 2-bit byte counter.
  - Then RD_TYPE -> RD_START -> RD_POLL.
- FIFO_RD:
  - 512 reads of 0x10.
  - buf_wr pulses one cycle after each ack, with buf_data = captured byte and buf_addr incrementing 0..511.
  - buf_sect is held for the whole sector.
  - After byte 511: buf_addr wraps to 0 and the sector counter decrements.
    - Remaining sectors = 0: go to DONE, which pulses rd_done, clears rd_busy, returns to IDLE.
    - Else: sector address + 1 (wraps at SEC_ADDR_W), buf_sect + 1, go to SECT_WAIT.
- SECT_WAIT: stay while buf_ready = 0; on buf_ready = 1 go to ADDR.
- Read error or timeout in RD_POLL: pulse rd_err, clear rd_busy, return to IDLE. init_done stays 1.
- wb_ack_i without stb is ignored.

Test Plan:
- Reset, ack after 1 cycle, status 0x01 twice then 0x00 -> writes 0x02=01, 0x03=01; 3 polls; init_done=1 about 15+ cycles after reset; no buf_wr.
- BLOCK_ADDR=0, rd_sector=0x000123, rd_count=1, FIFO returns byte = index[7:0] -> address bytes 00,46,02,00; 512 buf_wr with addr 0..511, data 0x00..0xFF twice; one rd_done; buf_sect=0.
- BLOCK_ADDR=1, rd_sector=0x7FFFFF, rd_count=3, buf_ready low 20 cycles after sector 0 -> address bytes FF,FF,7F,00, then 00,00,00,00 (wrap); stall held with no WB traffic; buf_sect 0,1,2; 1536 writes; single rd_done.
- Status stuck 0x01, POLL_LIMIT=8 during read -> exactly 8 polls, rd_err pulse, rd_busy=0; next rd_start accepted.
- Init status 0x05 every attempt, INIT_RETRY=2 -> 3 init sequences, init_err=1, init_done=0, later rd_start ignored.
- Reset asserted at FIFO byte 200 -> all outputs 0 asynchronously; init repeats after release; rd_count=0 request -> rd_done next cycle, no stb.
